// File: rtl/game_pkg.sv
// Shared types and the line position map for the 4x4 slide/merge game.
package game_pkg;

  typedef logic [3:0]        cell_t;
  typedef logic [15:0][3:0]  board_t;

  typedef enum logic [1:0] {DIR_LEFT, DIR_RIGHT, DIR_UP, DIR_DOWN} dir_t;

  localparam cell_t CELL_EMPTY = 4'd0;
  localparam cell_t CELL_MAX   = 4'd15;

  // Board index of position j on line k, where j=0 is the edge tiles slide toward.
  function automatic logic [3:0] cell_pos(dir_t d, logic [1:0] k, logic [1:0] j);
    logic [3:0] idx;
    unique case (d)
      DIR_LEFT:  idx = {k, j};
      DIR_RIGHT: idx = {k, 2'd3 - j};
      DIR_UP:    idx = {j, k};
      DIR_DOWN:  idx = {2'd3 - j, k};
      default:   idx = {k, j};
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/line_merge.sv
// Combinational slide-and-merge of one 4-cell line toward position 0.
module line_merge
  import game_pkg::*;
#(
  parameter int unsigned WIN_EXP = 11,
  parameter int unsigned SCORE_W = 20
) (
  input  logic [3:0][3:0]    cells_in,
  output logic [3:0][3:0]    cells_out,
  output logic [SCORE_W-1:0] score,
  output logic               win_hit
);

  logic [4:0][3:0] comp;
  int unsigned     cnt;
  int unsigned     oi;
  int unsigned     res_e;
  logic            skip;

  always_comb begin
    comp      = '0;
    cells_out = '0;
    score     = '0;
    win_hit   = 1'b0;
    cnt       = 0;
    oi        = 0;
    res_e     = 0;
    skip      = 1'b0;

    for (int j = 0; j < 4; j++) begin
      if (cells_in[j] != CELL_EMPTY) begin
        comp[cnt] = cells_in[j];
        cnt       = cnt + 1;
      end
    end

    // comp[4] stays empty, so the last cell never finds a partner.
    for (int j = 0; j < 4; j++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (comp[j] != CELL_EMPTY && comp[j] != CELL_MAX && comp[j] == comp[j+1]) begin
        res_e         = int'(comp[j]) + 1;
        cells_out[oi] = cell_t'(res_e);
        score         = score + (SCORE_W'(1) << res_e);
        if (res_e >= WIN_EXP) win_hit = 1'b1;
        oi            = oi + 1;
        skip          = 1'b1;
      end else begin
        cells_out[oi] = comp[j];
        oi            = oi + 1;
      end
    end
  end

endmodule

// File: rtl/slide_merge_engine.sv
// Applies one move to the board, one line per clock, and reports moved/win/score.
module slide_merge_engine
  import game_pkg::*;
#(
  parameter int unsigned WIN_EXP = 11,
  parameter int unsigned SCORE_W = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          dir,
  input  logic [15:0][3:0]    board_in,
  output logic                busy,
  output logic                done,
  output logic [15:0][3:0]    board_out,
  output logic                moved,
  output logic                win,
  output logic [SCORE_W-1:0]  score_delta
);

  typedef enum logic [1:0] {StIdle, StLine, StDone} state_t;

  state_t             state_q, state_d;
  logic [1:0]         line_q, line_d;
  dir_t               dir_q, dir_d;
  board_t             work_q, work_d;
  board_t             orig_q, orig_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               win_q, win_d;

  logic [3:0][3:0]    line_in, line_out;
  logic [SCORE_W-1:0] line_score;
  logic               line_win;

  always_comb begin
    line_in = '0;
    for (int j = 0; j < 4; j++) begin
      line_in[j] = work_q[cell_pos(dir_q, line_q, 2'(j))];
    end
  end

  line_merge #(
    .WIN_EXP (WIN_EXP),
    .SCORE_W (SCORE_W)
  ) u_line_merge (
    .cells_in  (line_in),
    .cells_out (line_out),
    .score     (line_score),
    .win_hit   (line_win)
  );

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    dir_d   = dir_q;
    work_d  = work_q;
    orig_d  = orig_q;
    score_d = score_q;
    win_d   = win_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          orig_d  = board_in;
          work_d  = board_in;
          dir_d   = dir_t'(dir);
          line_d  = 2'd0;
          score_d = '0;
          win_d   = 1'b0;
          state_d = StLine;
        end
      end
      StLine: begin
        for (int j = 0; j < 4; j++) begin
          work_d[cell_pos(dir_q, line_q, 2'(j))] = line_out[j];
        end
        score_d = score_q + line_score;
        win_d   = win_q | line_win;
        line_d  = line_q + 2'd1;
        if (line_q == 2'd3) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      line_q  <= 2'd0;
      dir_q   <= DIR_LEFT;
      work_q  <= '0;
      orig_q  <= '0;
      score_q <= '0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      dir_q   <= dir_d;
      work_q  <= work_d;
      orig_q  <= orig_d;
      score_q <= score_d;
      win_q   <= win_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign board_out   = work_q;
  // Both copies are equal from accept onward and zero after reset, so this is only
  // nonzero once a line has actually changed.
  assign moved       = (work_q != orig_q);
  assign win         = win_q;
  assign score_delta = score_q;

endmodule

// File: tb/tb_slide_merge_engine.sv
// Directed plus randomized moves checked against a queue-based reference model.
module tb_slide_merge_engine;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [1:0]       dir;
  logic [15:0][3:0] board_in;
  logic             busy, done, moved, win;
  logic [15:0][3:0] board_out;
  logic [19:0]      score_delta;

  int checks = 0;
  int errors = 0;

  logic [15:0][3:0] exp_board;
  logic [19:0]      exp_score;
  logic             exp_win;
  logic             exp_moved;

  always #5 clk = ~clk;

  slide_merge_engine #(
    .WIN_EXP (11),
    .SCORE_W (20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dir         (dir),
    .board_in    (board_in),
    .busy        (busy),
    .done        (done),
    .board_out   (board_out),
    .moved       (moved),
    .win         (win),
    .score_delta (score_delta)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int idx_of(input int d, input int k, input int j);
    case (d)
      0:       return k * 4 + j;
      1:       return k * 4 + 3 - j;
      2:       return j * 4 + k;
      default: return (3 - j) * 4 + k;
    endcase
  endfunction

  // Reference: per line, pull nonzero tiles into a queue and pop them pairwise.
  function automatic void model(input logic [15:0][3:0] b, input int d,
                                output logic [15:0][3:0] o, output int unsigned sc,
                                output bit w);
    o  = '0;
    sc = 0;
    w  = 0;
    for (int k = 0; k < 4; k++) begin
      int unsigned q[$];
      int unsigned r[$];
      for (int j = 0; j < 4; j++) begin
        if (b[idx_of(d, k, j)] != 0) q.push_back(int'(b[idx_of(d, k, j)]));
      end
      while (q.size() > 0) begin
        int unsigned a;
        a = q.pop_front();
        if (q.size() > 0 && q[0] == a && a < 15) begin
          void'(q.pop_front());
          r.push_back(a + 1);
          sc = sc + (32'd1 << (a + 1));
          if (a + 1 >= 11) w = 1;
        end else begin
          r.push_back(a);
        end
      end
      for (int j = 0; j < r.size(); j++) o[idx_of(d, k, j)] = 4'(r[j]);
    end
  endfunction

  task automatic do_move(input logic [15:0][3:0] b, input logic [1:0] d, input string name);
    int unsigned sc;
    bit          w;
    int          waits;
    model(b, int'(d), exp_board, sc, w);
    exp_score = 20'(sc);
    exp_win   = w;
    exp_moved = (exp_board != b);
    board_in  = b;
    dir       = d;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    board_in  = '0;
    dir       = 2'd0;
    chk({name, " busy_after_accept"}, 64'(busy), 64'(1));
    waits = 0;
    while (!done && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    chk({name, " latency"}, 64'(waits), 64'(4));
    chk({name, " board"}, board_out, exp_board);
    chk({name, " score"}, 64'(score_delta), 64'(exp_score));
    chk({name, " win"}, 64'(win), 64'(exp_win));
    chk({name, " moved"}, 64'(moved), 64'(exp_moved));
    chk({name, " busy_in_done"}, 64'(busy), 64'(1));
    @(negedge clk);
    chk({name, " done_one_pulse"}, 64'(done), 64'(0));
    chk({name, " idle_not_busy"}, 64'(busy), 64'(0));
    chk({name, " board_held"}, board_out, exp_board);
  endtask

  initial begin
    logic [15:0][3:0] b;
    int               dones;
    int               r;

    rst_n    = 1'b0;
    start    = 1'b0;
    dir      = 2'd0;
    board_in = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset board", board_out, 64'(0));
    chk("reset score", 64'(score_delta), 64'(0));
    chk("reset moved_win", {62'd0, moved, win}, 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 1: left, row0 = [1,1,2,2]
    b = '0; b[0] = 4'd1; b[1] = 4'd1; b[2] = 4'd2; b[3] = 4'd2;
    do_move(b, 2'd0, "t1");
    chk("t1 row0", 64'(board_out[3:0]), 64'({4'd0, 4'd0, 4'd3, 4'd2}));
    chk("t1 score_const", 64'(score_delta), 64'(12));

    // 2: right, row1 = [1,1,1,0]
    b = '0; b[4] = 4'd1; b[5] = 4'd1; b[6] = 4'd1;
    do_move(b, 2'd1, "t2");
    chk("t2 row1", 64'(board_out[7:4]), 64'({4'd2, 4'd1, 4'd0, 4'd0}));
    chk("t2 score_const", 64'(score_delta), 64'(4));

    // 3: up, col2 top->bottom = [0,10,0,10]
    b = '0; b[6] = 4'd10; b[14] = 4'd10;
    do_move(b, 2'd2, "t3");
    chk("t3 cell2", 64'(board_out[2]), 64'(11));
    chk("t3 win_const", 64'(win), 64'(1));
    chk("t3 score_const", 64'(score_delta), 64'(2048));

    // 4: left on a board already packed with no equal neighbours
    b = '0;
    b[0] = 4'd1;  b[1] = 4'd2;  b[2] = 4'd3;
    b[4] = 4'd2;  b[5] = 4'd1;
    b[8] = 4'd3;  b[9] = 4'd4;  b[10] = 4'd5; b[11] = 4'd6;
    do_move(b, 2'd0, "t4");
    chk("t4 unchanged", board_out, b);
    chk("t4 moved_const", 64'(moved), 64'(0));

    // Empty board still pulses done
    do_move('0, 2'd3, "empty");

    // 5: down, col0 = [15,15,0,0] never merges
    b = '0; b[0] = 4'd15; b[4] = 4'd15;
    do_move(b, 2'd3, "t5");
    chk("t5 col0_bottom", 64'({board_out[12], board_out[8], board_out[4], board_out[0]}),
        64'({4'd15, 4'd15, 4'd0, 4'd0}));
    chk("t5 moved_const", 64'(moved), 64'(1));

    // Randomized moves, each issued at the earliest accept point after the last
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 16; i++) begin
        r = int'($urandom_range(0, 15));
        if (r < 6)        b[i] = 4'd0;
        else if (r < 13)  b[i] = 4'($urandom_range(1, 3));
        else if (r == 13) b[i] = 4'd10;
        else if (r == 14) b[i] = 4'd14;
        else              b[i] = 4'd15;
      end
      do_move(b, 2'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
    end

    // 6: reset two edges after accept discards the move
    b = '0; b[0] = 4'd1; b[1] = 4'd1;
    board_in = b;
    dir      = 2'd0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid busy", 64'(busy), 64'(0));
    chk("rst_mid done", 64'(done), 64'(0));
    chk("rst_mid board", board_out, 64'(0));
    chk("rst_mid flags", {42'd0, score_delta, moved, win}, 64'(0));
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("rst_mid no_done", 64'(dones), 64'(0));

    // Start pulsed while busy is ignored: exactly one done
    board_in = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 1 || i == 4) begin
        start    = 1'b1;
        board_in = '1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) dones++;
    end
    start = 1'b0;
    chk("busy_start one_done", 64'(dones), 64'(1));
    chk("busy_start result", 64'(board_out[3:0]), 64'({4'd0, 4'd0, 4'd0, 4'd2}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
